// File: rtl/sd_cmd_sequencer.sv
// SD command/response sequencer: issues one command, collects its response and
// handles the no-response timeout, CRC-error re-sends and the inter-command gap.
module sd_cmd_sequencer #(
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned MAX_RETRY  = 2,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic         ex_clk,
  input  logic         reset,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         tx_start,
  output logic [5:0]   tx_index,
  output logic [31:0]  tx_arg,
  input  logic         tx_done,
  output logic         receive_en,
  output logic         R2_response,
  output logic         R3_response,
  input  logic         sd_receive_started,
  input  logic         sd_receive_finished,
  input  logic         crc_err,
  input  logic [126:0] response,
  output logic [126:0] resp_data,
  output logic         cmd_busy,
  output logic         cmd_done,
  output logic [1:0]   cmd_status,
  output logic [1:0]   retry_cnt
);

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned ARG_W  = 32;
  localparam int unsigned RESP_W = 127;
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_CRC = 2'b01;
  localparam logic [1:0] ST_TMO = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_TX = 3'd2,
    RECV    = 3'd3,
    GAP     = 3'd4,
    FINISH  = 3'd5
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ARG_W-1:0]  arg_q, arg_d;
  logic [1:0]        type_q, type_d;
  logic              r2_q, r2_d;
  logic              r3_q, r3_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [1:0]        status_q, status_d;
  logic [1:0]        retry_q, retry_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              started_q, started_d;
  logic              resend_q, resend_d;
  logic              tx_start_q, tx_start_d;
  logic              recv_en_q, recv_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Receive outcome decode; a finish always beats a same-cycle expiry
  logic crc_bad, retry_left, finish_ok, finish_retry, finish_fail, expire, gap_last;

  assign crc_bad      = crc_err && !r3_q;
  assign retry_left   = retry_q < 2'(MAX_RETRY);
  assign finish_ok    = sd_receive_finished && !crc_bad;
  assign finish_retry = sd_receive_finished && crc_bad && retry_left;
  assign finish_fail  = sd_receive_finished && crc_bad && !retry_left;
  assign expire       = !sd_receive_finished && !started_q && !sd_receive_started &&
                        (timer_q == TMR_W'(TIMEOUT - 1));
  assign gap_last     = gap_q == GAP_W'(GAP_CYCLES - 1);

  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_start) state_d = SEND;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (tx_done) state_d = (type_q == 2'b00) ? GAP : RECV;
      RECV:    if (sd_receive_finished || expire) state_d = GAP;
      GAP:     if (gap_last) state_d = resend_q ? SEND : FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath; pulse outputs are registered from the next state
  always_comb begin
    tx_start_d = (state_d == SEND);
    recv_en_d  = (state_q == WAIT_TX) && (state_d == RECV);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
    idx_d      = idx_q;
    arg_d      = arg_q;
    type_d     = type_q;
    r2_d       = r2_q;
    r3_d       = r3_q;
    resp_d     = resp_q;
    status_d   = status_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    started_d  = started_q;
    resend_d   = resend_q;
    gap_d      = '0;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          idx_d    = cmd_index;
          arg_d    = cmd_arg;
          type_d   = resp_type;
          r2_d     = (resp_type == 2'b10);
          r3_d     = (resp_type == 2'b11);
          retry_d  = '0;
          status_d = ST_OK;
          resend_d = 1'b0;
        end
      end
      WAIT_TX: begin
        if (tx_done) begin
          timer_d   = '0;
          started_d = 1'b0;
          if (type_q == 2'b00) status_d = ST_OK;
        end
      end
      RECV: begin
        if (sd_receive_started) started_d = 1'b1;
        if (!started_q) timer_d = timer_q + TMR_W'(1);
        if (finish_ok) begin
          resp_d   = response;
          status_d = ST_OK;
        end else if (finish_retry) begin
          retry_d  = retry_q + 2'd1;
          resend_d = 1'b1;
        end else if (finish_fail) begin
          status_d = ST_CRC;
        end else if (expire) begin
          status_d = ST_TMO;
        end
      end
      GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_last) resend_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      arg_q      <= '0;
      type_q     <= '0;
      r2_q       <= 1'b0;
      r3_q       <= 1'b0;
      resp_q     <= '0;
      status_q   <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      gap_q      <= '0;
      started_q  <= 1'b0;
      resend_q   <= 1'b0;
      tx_start_q <= 1'b0;
      recv_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      arg_q      <= arg_d;
      type_q     <= type_d;
      r2_q       <= r2_d;
      r3_q       <= r3_d;
      resp_q     <= resp_d;
      status_q   <= status_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      started_q  <= started_d;
      resend_q   <= resend_d;
      tx_start_q <= tx_start_d;
      recv_en_q  <= recv_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_index    = idx_q;
  assign tx_arg      = arg_q;
  assign receive_en  = recv_en_q;
  assign R2_response = r2_q;
  assign R3_response = r3_q;
  assign resp_data   = resp_q;
  assign cmd_busy    = busy_q;
  assign cmd_done    = done_q;
  assign cmd_status  = status_q;
  assign retry_cnt   = retry_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: plays transmitter and sd_receive, predicting each
// transaction's outcome from per-attempt receive scenarios.
module tb_sd_cmd_sequencer;

  localparam int TIMEOUT   = 1024;
  localparam int MAX_RETRY = 2;
  localparam int GAP       = 16;
  localparam int NEVER     = 1000000;

  logic         ex_clk = 1'b0;
  logic         reset;
  logic         cmd_start;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         tx_start;
  logic [5:0]   tx_index;
  logic [31:0]  tx_arg;
  logic         tx_done;
  logic         receive_en;
  logic         R2_response;
  logic         R3_response;
  logic         sd_receive_started;
  logic         sd_receive_finished;
  logic         crc_err;
  logic [126:0] response;
  logic [126:0] resp_data;
  logic         cmd_busy;
  logic         cmd_done;
  logic [1:0]   cmd_status;
  logic [1:0]   retry_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_tx = 0;
  int n_rxen = 0;
  int n_done = 0;
  logic [126:0] exp_resp;

  // Per-attempt receive scenario: cycle offsets from RECV entry (NEVER = absent)
  int           att_start [4];
  int           att_fin   [4];
  logic         att_crc   [4];
  logic [126:0] att_resp  [4];

  sd_cmd_sequencer #(
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY),
    .GAP_CYCLES(GAP)
  ) dut (
    .ex_clk             (ex_clk),
    .reset              (reset),
    .cmd_start          (cmd_start),
    .cmd_index          (cmd_index),
    .cmd_arg            (cmd_arg),
    .resp_type          (resp_type),
    .tx_start           (tx_start),
    .tx_index           (tx_index),
    .tx_arg             (tx_arg),
    .tx_done            (tx_done),
    .receive_en         (receive_en),
    .R2_response        (R2_response),
    .R3_response        (R3_response),
    .sd_receive_started (sd_receive_started),
    .sd_receive_finished(sd_receive_finished),
    .crc_err            (crc_err),
    .response           (response),
    .resp_data          (resp_data),
    .cmd_busy           (cmd_busy),
    .cmd_done           (cmd_done),
    .cmd_status         (cmd_status),
    .retry_cnt          (retry_cnt)
  );

  always #5 ex_clk = ~ex_clk;

  always @(posedge ex_clk) cyc <= cyc + 1;

  always @(negedge ex_clk) begin
    if (tx_start === 1'b1)   n_tx   <= n_tx + 1;
    if (receive_en === 1'b1) n_rxen <= n_rxen + 1;
    if (cmd_done === 1'b1)   n_done <= n_done + 1;
  end

  task automatic tick();
    @(posedge ex_clk);
    #1;
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [126:0] obs, input logic [126:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [126:0] rand127();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v[126:0];
  endfunction

  task automatic set_att(input int a, input int s, input int f, input logic c);
    att_start[a] = s;
    att_fin[a]   = f;
    att_crc[a]   = c;
    att_resp[a]  = rand127();
  endtask

  // No start bit and no finish within TIMEOUT cycles of RECV entry
  function automatic bit is_timeout(input int a);
    return (att_start[a] >= TIMEOUT) && (att_fin[a] >= TIMEOUT);
  endfunction

  // Transaction-level outcome: attempts used, final status, re-sends, winning attempt
  task automatic model(input logic [1:0] typ, output int n_att, output int st,
                       output int rc, output int ok_idx);
    n_att = 1; st = 0; rc = 0; ok_idx = -1;
    if (typ == 2'd0) return;
    for (int a = 0; a < 4; a++) begin
      n_att = a + 1;
      if (is_timeout(a)) begin st = 2; return; end
      if (!att_crc[a] || typ == 2'd3) begin ok_idx = a; return; end
      if (rc == MAX_RETRY) begin st = 1; return; end
      rc++;
    end
  endtask

  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] typ, input bit poke);
    int n_att, st, rc, ok_idx, tx0, rx0, dn0, gap_entry, lastk;
    bit seen;
    model(typ, n_att, st, rc, ok_idx);
    if (ok_idx >= 0) exp_resp = att_resp[ok_idx];
    tx0 = n_tx; rx0 = n_rxen; dn0 = n_done; gap_entry = 0;
    cmd_index = idx; cmd_arg = arg; resp_type = typ; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    cmd_index = 6'($urandom); cmd_arg = $urandom; resp_type = 2'($urandom);
    check_i("tx_start_latency", int'(tx_start), 1);
    check_i("busy_after_accept", int'(cmd_busy), 1);
    for (int a = 0; a < n_att; a++) begin
      if (a > 0) begin
        seen = 1'b0;
        for (int w = 0; w < GAP + 4 && !seen; w++) begin
          tick();
          seen = (tx_start === 1'b1);
        end
        check_i("resend_tx_start_cycle", seen ? cyc : -1, gap_entry + GAP);
      end
      tick();
      repeat ($urandom_range(0, 3)) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check_i("receive_en", int'(receive_en), int'(typ != 2'd0));
      if (typ != 2'd0) begin
        lastk = is_timeout(a) ? TIMEOUT - 1 : att_fin[a];
        for (int k = 0; k <= lastk; k++) begin
          sd_receive_started  = (k == att_start[a]);
          sd_receive_finished = (k == att_fin[a]);
          crc_err   = (k == att_fin[a]) ? att_crc[a] : 1'($urandom);
          response  = (k == att_fin[a]) ? att_resp[a] : rand127();
          cmd_start = poke && (k == 3);
          cmd_arg   = ~arg;
          tick();
        end
        sd_receive_started = 1'b0; sd_receive_finished = 1'b0;
        crc_err = 1'b0; cmd_start = 1'b0;
      end
      gap_entry = cyc;
    end
    seen = 1'b0;
    for (int w = 0; w < GAP + 4 && !seen; w++) begin
      tick();
      seen = (cmd_done === 1'b1);
    end
    check_i("cmd_done_cycle", seen ? cyc : -1, gap_entry + GAP);
    check_i("cmd_status", int'(cmd_status), st);
    check_i("retry_cnt", int'(retry_cnt), rc);
    check_w("resp_data", resp_data, exp_resp);
    check_i("tx_index_stable", int'(tx_index), int'(idx));
    check_w("tx_arg_stable", 127'(tx_arg), 127'(arg));
    check_i("r2_flag", int'(R2_response), int'(typ == 2'd2));
    check_i("r3_flag", int'(R3_response), int'(typ == 2'd3));
    tick();
    check_i("busy_after_done", int'(cmd_busy), 0);
    check_i("tx_start_count", n_tx - tx0, n_att);
    check_i("receive_en_count", n_rxen - rx0, (typ == 2'd0) ? 0 : n_att);
    check_i("done_count", n_done - dn0, 1);
  endtask

  initial begin
    int s, dn;
    reset = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_type = '0;
    tx_done = 1'b0; sd_receive_started = 1'b0; sd_receive_finished = 1'b0;
    crc_err = 1'b0; response = '0; exp_resp = '0;
    for (int a = 0; a < 4; a++) set_att(a, 1, 4, 1'b0);
    repeat (3) @(posedge ex_clk);
    #1;
    check_i("rst_busy", int'(cmd_busy), 0);
    check_i("rst_tx_start", int'(tx_start), 0);
    check_i("rst_done", int'(cmd_done), 0);
    check_i("rst_status", int'(cmd_status), 0);
    check_w("rst_resp", resp_data, '0);
    @(negedge ex_clk);
    reset = 1'b0;
    tick();
    check_i("idle_busy", int'(cmd_busy), 0);

    run_txn(6'd0, 32'h0, 2'b00, 1'b0);

    set_att(0, 2, 7, 1'b0);
    run_txn(6'd17, 32'h0000_0200, 2'b01, 1'b0);

    set_att(0, 1, 5, 1'b1); set_att(1, 3, 9, 1'b1); set_att(2, 0, 6, 1'b0);
    run_txn(6'd17, 32'h0000_0400, 2'b01, 1'b0);

    for (int a = 0; a < 4; a++) set_att(a, 1, 3 + a, 1'b1);
    run_txn(6'd18, 32'h0000_0600, 2'b01, 1'b0);

    set_att(0, NEVER, NEVER, 1'b0);
    run_txn(6'd2, 32'h0, 2'b10, 1'b1);

    set_att(0, TIMEOUT - 1, TIMEOUT + 3, 1'b0);
    run_txn(6'd9, 32'h1234_0000, 2'b10, 1'b0);

    set_att(0, NEVER, TIMEOUT - 1, 1'b0);
    run_txn(6'd13, 32'h5678_0000, 2'b01, 1'b0);

    set_att(0, 2, 8, 1'b1); set_att(1, 2, 8, 1'b0);
    run_txn(6'd41, 32'h40FF_8000, 2'b11, 1'b0);

    // Reset while receiving
    cmd_index = 6'd55; cmd_arg = 32'hDEAD_BEEF; resp_type = 2'b10; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_i("rst_test_receive_en", int'(receive_en), 1);
    tick();
    tick();
    dn = n_done;
    #2 reset = 1'b1;
    #1;
    exp_resp = '0;
    check_i("async_rst_busy", int'(cmd_busy), 0);
    check_i("async_rst_r2", int'(R2_response), 0);
    check_i("async_rst_index", int'(tx_index), 0);
    check_w("async_rst_arg", 127'(tx_arg), '0);
    check_w("async_rst_resp", resp_data, exp_resp);
    check_i("async_rst_status", int'(cmd_status), 0);
    check_i("async_rst_retry", int'(retry_cnt), 0);
    @(negedge ex_clk);
    reset = 1'b0;
    repeat (GAP + 8) tick();
    check_i("rst_no_done", n_done - dn, 0);
    check_i("rst_idle", int'(cmd_busy), 0);

    for (int n = 0; n < 12; n++) begin
      for (int a = 0; a < 4; a++) begin
        s = int'($urandom_range(0, 6));
        set_att(a, s, s + int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
      end
      run_txn(6'($urandom), $urandom, 2'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Sequences one complete SD command/response transaction: command transmit, response receive, no-response timeout, CRC-error retry, and the mandatory inter-command gap.
- Sits between the host register interface and the command transmitter / sd_receive pair.
- Drives the sd_receive controls (receive_en, R2_response, R3_response) and consumes its status (sd_receive_started, sd_receive_finished, crc_err, response).
- Runs entirely on ex_clk.

Parameters:
- TIMEOUT, 1024, ex_clk cycles allowed from receive start (RECV entry) to sd_receive_started before a no-response timeout.
- MAX_RETRY, 2, number of re-sends allowed after a CRC error (0 disables retry).
- GAP_CYCLES, 16, ex_clk cycles held idle after every transaction or before a re-send (covers NRC ≥ 8 SD clocks).

Ports:
- ex_clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_start  in  1  request pulse; accepted only in IDLE
- cmd_index  in  6  command index, latched on accept
- cmd_arg  in  32  command argument, latched on accept
- resp_type  in  2  00 none, 01 48-bit with CRC (R1/R6/R7), 10 R2, 11 R3; latched on accept
- tx_start  out  1  one-cycle pulse to the command transmitter
- tx_index  out  6  latched cmd_index
- tx_arg  out  32  latched cmd_arg
- tx_done  in  1  transmitter completion pulse
- receive_en  out  1  one-cycle pulse to sd_receive
- R2_response  out  1  latched (resp_type==10)
- R3_response  out  1  latched (resp_type==11)
- sd_receive_started  in  1  start bit detected
- sd_receive_finished  in  1  receive plus CRC check complete (pulse)
- crc_err  in  1  valid in the sd_receive_finished cycle
- response  in  127  sd_receive response bus
- resp_data  out  127  response captured on successful completion
- cmd_busy  out  1  high in every state except IDLE
- cmd_done  out  1  one-cycle completion pulse
- cmd_status  out  2  00 OK, 01 CRC error, 10 timeout; held until next accept
- retry_cnt  out  2  re-sends used in the current transaction

Behaviour:
Reset values:
- All outputs 0; state IDLE; timer, retry_cnt and started flag cleared.
- Reset mid-transaction aborts immediately with no cmd_done.

States: IDLE, SEND, WAIT_TX, RECV, GAP, FINISH.

- IDLE: cmd_start=1 latches index/arg/type, clears retry_cnt and cmd_status, and moves to SEND. cmd_start in any other state is ignored.
- SEND: tx_start=1 for exactly one cycle, then WAIT_TX.
- WAIT_TX:
  - On tx_done with type 00: go to GAP, status OK.
  - On tx_done with any other type: go to RECV, clear timer and started flag.
  - WAIT_TX has no timeout.
- RECV:
  - receive_en=1 only on the first RECV cycle.
  - Started flag is set on sd_receive_started and is sticky.
  - Timer increments each cycle while the started flag is clear.
  - Timer reaching TIMEOUT-1 with the flag still clear: go to GAP, status 10, no retry.
  - sd_receive_finished:
    - crc_err=0, or type R3 (crc_err ignored for R3): resp_data<=response, status 00, go to GAP.
    - crc_err=1 and retry_cnt<MAX_RETRY: retry_cnt+1, go to GAP with a resend flag set.
    - crc_err=1 and retry_cnt==MAX_RETRY: status 01, go to GAP.
  - Finished and timer expiry in the same cycle: finished wins.
  - Started seen in the expiry cycle: no timeout.
- GAP:
  - Counts GAP_CYCLES cycles.
  - Then goes to SEND if the resend flag is set (flag clears), otherwise to FINISH.
- FINISH: cmd_done=1 for one cycle, then IDLE.

Latency and invariants:
- cmd_start to tx_start is 1 cycle.
- tx_index, tx_arg, R2_response and R3_response stay stable from accept until IDLE.
- resp_data is updated only on success; otherwise it keeps its previous value.

Test Plan:
- CMD0, type 00: cmd_start → tx_start 1 cycle later; tx_done → no receive_en; cmd_done GAP_CYCLES+1 cycles after tx_done; status 00.
- CMD17, type 01, arg 0x00000200: finished with crc_err=0 and response=X → exactly one receive_en pulse, resp_data==X, status 00, retry_cnt 0.
- Type 01 with crc_err=1 on the first two receives and 0 on the third → three tx_start pulses each separated by a gap, retry_cnt 2, status 00; with four consecutive errors → status 01, cmd_done, resp_data unchanged.
- Type 10 (R2) with sd_receive_started never asserted → status 10 exactly TIMEOUT+GAP_CYCLES cycles after RECV entry; R2_response high throughout; second variant with started at cycle TIMEOUT-1 → no timeout.
- Type 11 (R3) with crc_err=1 at finish → treated as OK, resp_data captured, no retry.
- reset asserted in RECV → all outputs 0 asynchronously, IDLE; cmd_start during busy → ignored, latched arg unchanged.
